// File: rtl/cqu_mips_pkg.sv
// Shared definitions for the CPU bus-side blocks: transfer size encodings and
// a clog2 that never returns zero, so it can size a pointer for any depth.
package cqu_mips_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  function automatic int clog2_safe(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy count, so any depth works.
// Push while full is accepted when a pop happens in the same cycle.
module sync_fifo
  import cqu_mips_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2,
  localparam int PTR_W = clog2_safe(DEPTH),
  localparam int CNT_W = clog2_safe(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W-1:0] rd_ptr_next, wr_ptr_next;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips an assignment infers a latch.
  always_comb begin
    rd_ptr_next = rd_ptr + 1'b1;
    wr_ptr_next = wr_ptr + 1'b1;
    if (rd_ptr == PTR_W'(DEPTH - 1)) rd_ptr_next = '0;
    if (wr_ptr == PTR_W'(DEPTH - 1)) wr_ptr_next = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr_next;
      if (do_pop)  rd_ptr <= rd_ptr_next;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity,
  // and leaving the array out of reset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sram_like_port.sv
// Master-side sram-like channel controller: credit-gated request pass-through,
// in-order response buffering, and flush that drains responses still in flight.
module sram_like_port
  import cqu_mips_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int RESP_DEPTH      = 4,
  parameter int ALLOW_WRITE     = 1,
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1),
  localparam int RC_W  = clog2_safe(RESP_DEPTH + 1),
  localparam int TC_W  = clog2_safe(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              core_valid,
  input  logic              core_wr,
  input  logic [1:0]        core_size,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_wr,
  input  logic              resp_ready,
  output logic              stall,
  output logic [OUT_W-1:0]  outstanding,
  output logic              proto_err,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok
);

  localparam logic WR_EN = (ALLOW_WRITE != 0);

  logic [OUT_W-1:0]  drop_cnt;
  logic [RC_W-1:0]   fifo_count;
  logic              credit;
  logic              accept;
  logic              data_ok_valid;
  logic              resp_push;
  logic              resp_empty;
  logic              resp_full;
  logic              tag_head;
  logic              tag_empty, tag_full;
  logic [TC_W-1:0]   tag_count;
  logic              unused_status;

  // Counting buffered plus in-flight entries reserves a slot for every data_ok.
  assign credit = (int'(outstanding) < MAX_OUTSTANDING) &&
                  ((int'(outstanding) + int'(fifo_count)) < RESP_DEPTH);

  assign bus_req    = rstn & core_valid & credit & ~flush;
  assign bus_wr     = core_wr & WR_EN;
  assign bus_size   = core_size;
  assign bus_addr   = core_addr;
  assign bus_wdata  = core_wdata;
  assign core_ready = bus_req & bus_addr_ok;
  assign stall      = core_valid & ~core_ready;
  assign accept     = core_ready;

  // A data_ok with nothing in flight is a protocol error and is otherwise ignored.
  assign data_ok_valid = bus_data_ok & (outstanding != '0);
  assign resp_push     = data_ok_valid & ~flush & (drop_cnt == '0);
  assign resp_valid    = ~resp_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      proto_err   <= 1'b0;
    end else begin
      if (bus_data_ok && outstanding == '0) proto_err <= 1'b1;

      case ({accept, data_ok_valid})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      // Responses still owed by the bus after a flush are swallowed on arrival.
      if (flush) begin
        drop_cnt <= outstanding - OUT_W'(data_ok_valid);
      end else if (data_ok_valid && drop_cnt != '0) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  // Request-type tags stay aligned with outstanding, including dropped ones.
  sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (1'b0),
    .push  (accept),
    .din   (bus_wr),
    .pop   (data_ok_valid),
    .dout  (tag_head),
    .empty (tag_empty),
    .full  (tag_full),
    .count (tag_count)
  );

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clear (flush),
    .push  (resp_push),
    .din   ({tag_head, bus_rdata}),
    .pop   (resp_ready),
    .dout  ({resp_wr, resp_rdata}),
    .empty (resp_empty),
    .full  (resp_full),
    .count (fifo_count)
  );

  assign unused_status = &{1'b0, tag_empty, tag_full, tag_count, resp_full};

endmodule
